// File: rtl/bpm_link_arb_pkg.sv
// rtl/bpm_link_arb_pkg.sv - shared constants, output-stage states and grant helper for bpm_link_arbiter
package bpm_link_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 112;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  localparam logic SRC_CCW = 1'b0;
  localparam logic SRC_CW  = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } outState_t;

  // With both links backlogged the source that did not win last time gets the slot.
  function automatic logic pickSource(input logic ccwReady, input logic cwReady,
                                      input logic lastGrant);
    if (ccwReady && cwReady) begin
      return ~lastGrant;
    end else if (cwReady) begin
      return SRC_CW;
    end else begin
      return SRC_CCW;
    end
  endfunction

endpackage

// File: rtl/bpm_link_arbiter_if.sv
// rtl/bpm_link_arbiter_if.sv - link record inputs and merged stream output of bpm_link_arbiter
interface bpm_link_arbiter_if
  import bpm_link_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  ccwStrobe;
  logic [DATA_WIDTH-1:0] ccwData;
  logic                  cwStrobe;
  logic [DATA_WIDTH-1:0] cwData;
  logic [DATA_WIDTH-1:0] mergedTDATA;
  logic                  mergedTUSER;
  logic                  mergedTVALID;
  logic                  mergedTREADY;

  modport master (
    output ccwStrobe, ccwData, cwStrobe, cwData, mergedTREADY,
    input  mergedTDATA, mergedTUSER, mergedTVALID
  );

  modport slave (
    input  ccwStrobe, ccwData, cwStrobe, cwData, mergedTREADY,
    output mergedTDATA, mergedTUSER, mergedTVALID
  );

endinterface

// File: rtl/bpm_link_fifo.sv
// rtl/bpm_link_fifo.sv - per-link synchronous FIFO with flush and registered occupancy level
module bpm_link_fifo #(
  parameter int DATA_WIDTH  = 112,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   wrEn,
  input  logic [DATA_WIDTH-1:0]  wrData,
  input  logic                   rdEn,
  output logic [DATA_WIDTH-1:0]  rdData,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wrPtr;
  logic [PTR_WIDTH-1:0]  rdPtr;
  logic                  doWrite;
  logic                  doRead;

  // Full is judged on the registered level, so a read in the same cycle never frees a slot early.
  assign full    = (level == LEVEL_WIDTH'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign doWrite = wrEn && !full && !flush;
  assign doRead  = rdEn && !empty && !flush;
  assign rdData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doWrite) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doRead) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doWrite && !doRead) begin
        level <= level + 1'b1;
      end else if (doRead && !doWrite) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpm_link_arbiter.sv
// rtl/bpm_link_arbiter.sv - round-robin merge of CCW/CW BPM link records into one valid/ready stream
// Optional saturating drop counters are built when BPM_ARB_STATS_EN is defined.
module bpm_link_arbiter
  import bpm_link_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
`ifdef BPM_ARB_STATS_EN
  ,
  parameter int STAT_WIDTH  = 16
`endif
) (
  input  logic                   auroraUserClk,
  input  logic                   auroraResetN,
  input  logic                   flush,
  bpm_link_arbiter_if.slave      link,
  output logic [LEVEL_WIDTH-1:0] ccwLevel,
  output logic [LEVEL_WIDTH-1:0] cwLevel,
  output logic                   ccwOverflow,
  output logic                   cwOverflow
`ifdef BPM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]  ccwDropCount,
  output logic [STAT_WIDTH-1:0]  cwDropCount
`endif
);

  logic                  ccwFull;
  logic                  cwFull;
  logic                  ccwEmpty;
  logic                  cwEmpty;
  logic [DATA_WIDTH-1:0] ccwRdData;
  logic [DATA_WIDTH-1:0] cwRdData;
  logic                  ccwDrop;
  logic                  cwDrop;
  logic                  pop;
  logic                  popSrc;
  logic                  ccwPop;
  logic                  cwPop;
  logic                  lastGrant;
  outState_t             outState;
  logic [DATA_WIDTH-1:0] holdData;
  logic                  holdUser;

  assign ccwDrop = link.ccwStrobe && ccwFull && !flush;
  assign cwDrop  = link.cwStrobe && cwFull && !flush;

  // Refill the holding register when it is empty or is being handed over this cycle.
  assign popSrc = pickSource(!ccwEmpty, !cwEmpty, lastGrant);
  assign pop    = !flush && (!ccwEmpty || !cwEmpty) &&
                  ((outState == OUT_EMPTY) || link.mergedTREADY);
  assign ccwPop = pop && (popSrc == SRC_CCW);
  assign cwPop  = pop && (popSrc == SRC_CW);

  bpm_link_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEVEL_WIDTH(LEVEL_WIDTH)
  ) ccwFifo (
    .clk   (auroraUserClk),
    .rstN  (auroraResetN),
    .flush (flush),
    .wrEn  (link.ccwStrobe),
    .wrData(link.ccwData),
    .rdEn  (ccwPop),
    .rdData(ccwRdData),
    .level (ccwLevel),
    .full  (ccwFull),
    .empty (ccwEmpty)
  );

  bpm_link_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEVEL_WIDTH(LEVEL_WIDTH)
  ) cwFifo (
    .clk   (auroraUserClk),
    .rstN  (auroraResetN),
    .flush (flush),
    .wrEn  (link.cwStrobe),
    .wrData(link.cwData),
    .rdEn  (cwPop),
    .rdData(cwRdData),
    .level (cwLevel),
    .full  (cwFull),
    .empty (cwEmpty)
  );

  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      outState  <= OUT_EMPTY;
      lastGrant <= SRC_CW;
      holdData  <= '0;
      holdUser  <= SRC_CCW;
    end else if (flush) begin
      outState  <= OUT_EMPTY;
      lastGrant <= SRC_CW;
    end else begin
      if (pop) begin
        holdData  <= (popSrc == SRC_CW) ? cwRdData : ccwRdData;
        holdUser  <= popSrc;
        lastGrant <= popSrc;
        outState  <= OUT_FULL;
      end else if ((outState == OUT_FULL) && link.mergedTREADY) begin
        outState <= OUT_EMPTY;
      end
    end
  end

  assign link.mergedTVALID = (outState == OUT_FULL);
  assign link.mergedTDATA  = holdData;
  assign link.mergedTUSER  = holdUser;

  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      ccwOverflow <= 1'b0;
      cwOverflow  <= 1'b0;
    end else if (flush) begin
      ccwOverflow <= 1'b0;
      cwOverflow  <= 1'b0;
    end else begin
      if (ccwDrop) begin
        ccwOverflow <= 1'b1;
      end
      if (cwDrop) begin
        cwOverflow <= 1'b1;
      end
    end
  end

`ifdef BPM_ARB_STATS_EN
  // Session flush leaves these alone; only reset clears the lifetime counts.
  always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      ccwDropCount <= '0;
      cwDropCount  <= '0;
    end else begin
      if (ccwDrop && (ccwDropCount != '1)) begin
        ccwDropCount <= ccwDropCount + 1'b1;
      end
      if (cwDrop && (cwDropCount != '1)) begin
        cwDropCount <= cwDropCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bpm_link_arbiter.sv
// tb/tb_bpm_link_arbiter.sv - directed self-checking bench for bpm_link_arbiter
module tb_bpm_link_arbiter;
  import bpm_link_arb_pkg::*;

  localparam int DW = 112;
  localparam int FD = 16;
  localparam int LW = 5;
  localparam int SW = 16;

  logic          auroraUserClk = 1'b0;
  logic          auroraResetN  = 1'b0;
  logic          flush         = 1'b0;
  logic [LW-1:0] ccwLevel;
  logic [LW-1:0] cwLevel;
  logic          ccwOverflow;
  logic          cwOverflow;
`ifdef BPM_ARB_STATS_EN
  logic [SW-1:0] ccwDropCount;
  logic [SW-1:0] cwDropCount;
`endif

  int nVec = 0;
  int nMis = 0;

  bpm_link_arbiter_if #(.DATA_WIDTH(DW)) link ();

  bpm_link_arbiter #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .LEVEL_WIDTH(LW)
`ifdef BPM_ARB_STATS_EN
    ,
    .STAT_WIDTH (SW)
`endif
  ) dut (
    .auroraUserClk(auroraUserClk),
    .auroraResetN (auroraResetN),
    .flush        (flush),
    .link         (link),
    .ccwLevel     (ccwLevel),
    .cwLevel      (cwLevel),
    .ccwOverflow  (ccwOverflow),
    .cwOverflow   (cwOverflow)
`ifdef BPM_ARB_STATS_EN
    ,
    .ccwDropCount (ccwDropCount),
    .cwDropCount  (cwDropCount)
`endif
  );

  always #5 auroraUserClk = ~auroraUserClk;

  task automatic tick();
    @(posedge auroraUserClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ccwPat(input int i);
    return {16'hCC00, 32'(i), 64'h0123_4567_89AB_CDEF};
  endfunction

  function automatic logic [DW-1:0] cwPat(input int i);
    return {16'hC700, 32'(i), 64'hFEDC_BA98_7654_3210};
  endfunction

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] prevData;
    logic          prevStall;
    logic          rdy;
    int            k;
    int            expIdx;

    link.ccwStrobe    = 1'b0;
    link.ccwData      = '0;
    link.cwStrobe     = 1'b0;
    link.cwData       = '0;
    link.mergedTREADY = 1'b0;
    repeat (2) tick();

    chk("rst tvalid", link.mergedTVALID, 1'b0);
    chk("rst tdata", link.mergedTDATA, {DW{1'b0}});
    chk("rst tuser", link.mergedTUSER, 1'b0);
    chk("rst ccwLevel", ccwLevel, 5'd0);
    chk("rst cwLevel", cwLevel, 5'd0);
    chk("rst ccwOverflow", ccwOverflow, 1'b0);
    chk("rst cwOverflow", cwOverflow, 1'b0);
`ifdef BPM_ARB_STATS_EN
    chk("rst ccwDropCount", ccwDropCount, 16'd0);
`endif
    auroraResetN = 1'b1;
    tick();

    d1 = 112'hA5BE_0003_1111_2222_3333_4444_5555;
    link.mergedTREADY = 1'b1;
    link.ccwStrobe    = 1'b1;
    link.ccwData      = d1;
    tick();
    link.ccwStrobe = 1'b0;
    chk("t1 tvalid N+1", link.mergedTVALID, 1'b0);
    chk("t1 ccwLevel N+1", ccwLevel, 5'd1);
    tick();
    chk("t1 tvalid N+2", link.mergedTVALID, 1'b1);
    chk("t1 tuser", link.mergedTUSER, 1'b0);
    chk("t1 tdata", link.mergedTDATA, d1);
    tick();
    chk("t1 tvalid N+3", link.mergedTVALID, 1'b0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (link.mergedTVALID) begin
        chk("t2 tuser", link.mergedTUSER, k[0]);
        chk("t2 tdata", link.mergedTDATA, (k[0] ? cwPat(k / 2) : ccwPat(k / 2)));
        k++;
      end
      link.ccwStrobe = (c < 8);
      link.cwStrobe  = (c < 8);
      link.ccwData   = ccwPat(c);
      link.cwData    = cwPat(c);
      tick();
    end
    link.ccwStrobe = 1'b0;
    link.cwStrobe  = 1'b0;
    chk("t2 count", k, 16);
    chk("t2 ccwOverflow", ccwOverflow, 1'b0);
    chk("t2 cwOverflow", cwOverflow, 1'b0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    link.mergedTREADY = 1'b0;
    for (int i = 0; i < 17; i++) begin
      link.ccwStrobe = 1'b1;
      link.ccwData   = ccwPat(100 + i);
      tick();
    end
    link.ccwStrobe = 1'b0;
    tick();
    chk("t3 ccwLevel full", ccwLevel, 5'd16);
    chk("t3 tvalid", link.mergedTVALID, 1'b1);
    chk("t3 held tdata", link.mergedTDATA, ccwPat(100));
    chk("t3 no overflow yet", ccwOverflow, 1'b0);
    link.ccwStrobe = 1'b1;
    link.ccwData   = ccwPat(200);
    tick();
    link.ccwStrobe = 1'b0;
    chk("t3 ccwOverflow", ccwOverflow, 1'b1);
    chk("t3 ccwLevel after drop", ccwLevel, 5'd16);
    chk("t3 cwOverflow", cwOverflow, 1'b0);
`ifdef BPM_ARB_STATS_EN
    chk("t3 ccwDropCount", ccwDropCount, 16'd1);
`endif
    link.mergedTREADY = 1'b1;
    link.ccwStrobe    = 1'b1;
    link.ccwData      = ccwPat(201);
    tick();
    link.mergedTREADY = 1'b0;
    link.ccwStrobe    = 1'b0;
    chk("t3 ccwLevel read+drop", ccwLevel, 5'd15);
    chk("t3 tdata next", link.mergedTDATA, ccwPat(101));
`ifdef BPM_ARB_STATS_EN
    chk("t3 ccwDropCount 2", ccwDropCount, 16'd2);
`endif

    expIdx    = 101;
    prevStall = 1'b0;
    prevData  = '0;
    for (int c = 0; c < 300 && expIdx < 117; c++) begin
      rdy = 1'($urandom_range(0, 1));
      if (link.mergedTVALID) begin
        if (prevStall) chk("t4 hold stable", link.mergedTDATA, prevData);
        if (rdy) begin
          chk("t4 order", link.mergedTDATA, ccwPat(expIdx));
          expIdx++;
        end
      end
      prevStall = link.mergedTVALID && !rdy;
      prevData  = link.mergedTDATA;
      link.mergedTREADY = rdy;
      tick();
    end
    link.mergedTREADY = 1'b0;
    chk("t4 drained", expIdx, 117);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5 overflow cleared", ccwOverflow, 1'b0);
    for (int c = 0; c < 5; c++) begin
      link.ccwStrobe = (c < 4);
      link.cwStrobe  = 1'b1;
      link.ccwData   = ccwPat(300 + c);
      link.cwData    = cwPat(300 + c);
      tick();
    end
    link.ccwStrobe = 1'b0;
    link.cwStrobe  = 1'b0;
    chk("t5 ccwLevel", ccwLevel, 5'd3);
    chk("t5 cwLevel", cwLevel, 5'd5);
    chk("t5 tvalid", link.mergedTVALID, 1'b1);
    chk("t5 tdata", link.mergedTDATA, ccwPat(300));
    flush          = 1'b1;
    link.ccwStrobe = 1'b1;
    link.cwStrobe  = 1'b1;
    link.ccwData   = 112'hDEAD_0000_0000_0000_0000_0000_BEEF;
    link.cwData    = 112'hDEAD_0000_0000_0000_0000_0000_CAFE;
    tick();
    flush          = 1'b0;
    link.ccwStrobe = 1'b0;
    link.cwStrobe  = 1'b0;
    chk("t5 tvalid after flush", link.mergedTVALID, 1'b0);
    chk("t5 ccwLevel after flush", ccwLevel, 5'd0);
    chk("t5 cwLevel after flush", cwLevel, 5'd0);
    chk("t5 ccwOverflow after flush", ccwOverflow, 1'b0);
    chk("t5 cwOverflow after flush", cwOverflow, 1'b0);
    link.mergedTREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5 flush strobe discarded", link.mergedTVALID, 1'b0);
    end

    link.ccwStrobe = 1'b1;
    link.cwStrobe  = 1'b1;
    link.ccwData   = ccwPat(400);
    link.cwData    = cwPat(400);
    tick();
    link.ccwStrobe = 1'b0;
    link.cwStrobe  = 1'b0;
    tick();
    chk("t6 first tuser", link.mergedTUSER, 1'b0);
    chk("t6 first tdata", link.mergedTDATA, ccwPat(400));
    tick();
    chk("t6 second tuser", link.mergedTUSER, 1'b1);
    chk("t6 second tdata", link.mergedTDATA, cwPat(400));
    tick();
    chk("t6 idle", link.mergedTVALID, 1'b0);

    link.mergedTREADY = 1'b0;
    link.ccwStrobe    = 1'b1;
    link.ccwData      = ccwPat(500);
    tick();
    link.ccwStrobe = 1'b0;
    tick();
    chk("t7 tvalid before reset", link.mergedTVALID, 1'b1);
    #3;
    auroraResetN = 1'b0;
    #1;
    chk("t7 tvalid async", link.mergedTVALID, 1'b0);
    chk("t7 tdata async", link.mergedTDATA, {DW{1'b0}});
    chk("t7 tuser async", link.mergedTUSER, 1'b0);
    chk("t7 ccwLevel async", ccwLevel, 5'd0);
    chk("t7 ccwOverflow async", ccwOverflow, 1'b0);
`ifdef BPM_ARB_STATS_EN
    chk("t7 ccwDropCount async", ccwDropCount, 16'd0);
    chk("t7 cwDropCount async", cwDropCount, 16'd0);
`endif
    tick();
    auroraResetN = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
